// File: rtl/rate_generator.sv
// rate_generator: emits rate_act evenly spaced single-cycle pulses per CLK_FREQ-cycle window
// and reports the number of pulses emitted in each window as it closes.
module rate_generator #(
    parameter int unsigned CLK_FREQ = 125000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] rate_in,
    input  logic        rate_load,
    output logic        rate_ack,
    output logic        clamped,
    output logic        q,
    output logic        valid,
    output logic [31:0] last_count
);
    localparam logic [31:0] TOP  = 32'(CLK_FREQ - 1);
    localparam logic [31:0] HALF = 32'(CLK_FREQ / 2);
    localparam logic [32:0] FREQ = 33'(CLK_FREQ);

    logic [31:0] cnt_q, cnt_d, rate_q, rate_d, pend_val_q, pend_val_d;
    logic [31:0] count_q, count_d, last_q, last_d, new_rate;
    logic [32:0] acc_q, acc_d, sum;
    logic        pend_q, pend_d, clamped_q, clamped_d, pulse_q, pulse_d;
    logic        valid_q, valid_d, ack_q, ack_d;
    logic        boundary, fire, activate;

    always_comb begin
        boundary   = cnt_q == '0;
        sum        = acc_q + {1'b0, rate_q};
        fire       = sum >= FREQ;
        // a load on the boundary cycle itself wins over the older pending value
        new_rate   = rate_load ? rate_in : pend_val_q;
        activate   = (!en || boundary) && (rate_load || pend_q);
        cnt_d      = en ? (boundary ? TOP : cnt_q - 32'd1) : TOP;
        acc_d      = (!en || boundary) ? '0 : (fire ? sum - FREQ : sum);
        pulse_d    = en && fire;
        count_d    = (!en || boundary) ? '0 : count_q + {31'b0, fire};
        last_d     = (en && boundary) ? count_q + {31'b0, fire} : last_q;
        valid_d    = en && boundary;
        rate_d     = activate ? (new_rate > HALF ? HALF : new_rate) : rate_q;
        clamped_d  = activate ? new_rate > HALF : clamped_q;
        ack_d      = activate;
        pend_d     = activate ? 1'b0 : (rate_load ? 1'b1 : pend_q);
        pend_val_d = rate_load ? rate_in : pend_val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= TOP;
            acc_q      <= '0;
            rate_q     <= '0;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            count_q    <= '0;
            last_q     <= '0;
            clamped_q  <= 1'b0;
            pulse_q    <= 1'b0;
            valid_q    <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rate_q     <= rate_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            count_q    <= count_d;
            last_q     <= last_d;
            clamped_q  <= clamped_d;
            pulse_q    <= pulse_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
        end
    end

    assign q          = pulse_q;
    assign valid      = valid_q;
    assign last_count = last_q;
    assign clamped    = clamped_q;
    assign rate_ack   = ack_q;
endmodule

// File: tb/tb_rate_generator.sv
// tb_rate_generator: randomized window-level scoreboard for rate_generator at CLK_FREQ=100.
module tb_rate_generator;
    localparam int unsigned F = 100;

    logic        clk = 1'b0;
    logic        rst_n, en, rate_load, rate_ack, clamped, q, valid;
    logic [31:0] rate_in, last_count;

    rate_generator #(.CLK_FREQ(F)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rate_in(rate_in), .rate_load(rate_load),
        .rate_ack(rate_ack), .clamped(clamped), .q(q), .valid(valid), .last_count(last_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cnt;
        bit          ack;
        bit          clp;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, errors = 0;
    int          qcnt = 0, ackcnt = 0, prev_q = 0, kpos = 0;
    int unsigned cur_rate = 0, pend_val = 0;
    bit          pend = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int unsigned lim(int unsigned r);
        return r > F / 2 ? F / 2 : r;
    endfunction

    // Window-level reference: a window emits min(rate,F/2) pulses; the last load seen
    // during a window (boundary cycle included) becomes the rate of the next window.
    task automatic tick(bit ld, logic [31:0] v);
        exp_t e;
        en = 1'b1;
        rate_load = ld;
        rate_in = v;
        if (ld) begin
            pend = 1;
            pend_val = v;
        end
        if (kpos == F - 1) begin
            e.cnt = lim(cur_rate);
            e.ack = pend;
            if (pend) cur_rate = pend_val;
            pend = 0;
            e.clp = cur_rate > F / 2;
            sb.push_back(e);
            kpos = 0;
        end else kpos++;
        @(negedge clk);
    endtask

    function automatic bit dload(int w, int k, output logic [31:0] v);
        v = 32'd0;
        dload = 1'b1;
        if (w == 1 && k == 50) v = 32'd10;
        else if (w == 2 && k == 30) v = 32'd25;
        else if (w == 2 && k == 70) v = 32'd30;
        else if (w == 3 && k == 99) v = 32'd70;
        else if (w == 4 && k == 10) v = 32'd0;
        else if (w == 6 && k == 99) v = 32'd10;
        else dload = 1'b0;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #2;
        if (!rst_n || !en) begin
            qcnt = 0;
            ackcnt = 0;
            prev_q = 0;
        end else begin
            chk("q_gap", int'(q) & prev_q, 0);
            prev_q = int'(q);
            if (valid) begin
                chk("sb_nonempty", int'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("last_count", last_count, e.cnt);
                    chk("q_pulses", qcnt + int'(q), e.cnt);
                    chk("rate_ack", ackcnt + int'(rate_ack), int'(e.ack));
                    chk("clamped", clamped, e.clp);
                end
                qcnt = 0;
                ackcnt = 0;
            end else begin
                qcnt += int'(q);
                ackcnt += int'(rate_ack);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        bit ld;
        rst_n = 1'b0;
        en = 1'b0;
        rate_load = 1'b0;
        rate_in = '0;
        #1;
        chk("rst_q", q, 0);
        chk("rst_valid", valid, 0);
        chk("rst_last_count", last_count, 0);
        chk("rst_clamped", clamped, 0);
        chk("rst_ack", rate_ack, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rate_load = 1'b1;
        rate_in = 32'd20;
        @(negedge clk);
        rate_load = 1'b0;
        chk("ack_en0", rate_ack, 1);
        chk("clamped_en0", clamped, 0);
        @(negedge clk);
        chk("ack_single", rate_ack, 0);
        chk("q_idle_en0", q, 0);
        cur_rate = 20;
        for (int w = 0; w < 7; w++)
            for (int k = 0; k < int'(F); k++) begin
                ld = dload(w, k, v);
                tick(ld, v);
            end
        for (int w = 0; w < 8; w++)
            for (int k = 0; k < int'(F); k++) begin
                ld = $urandom_range(0, 39) == 0;
                v = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 80);
                tick(ld, v);
            end
        for (int k = 0; k < 40; k++) tick(1'b0, '0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_q", q, 0);
        chk("arst_valid", valid, 0);
        chk("arst_last_count", last_count, 0);
        chk("arst_clamped", clamped, 0);
        chk("arst_ack", rate_ack, 0);
        cur_rate = 0;
        pend = 0;
        kpos = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * int'(F); k++) tick(1'b0, '0);
        en = 1'b0;
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rate_generator.md
RATE_GENERATOR -- requirements
Module: rate_generator

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 125000000, meaning clock cycles per 1 s measurement window.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1, generator enable.
REQ-005 SHALL have port rate_in, input, 32, requested pulses per window.
REQ-006 SHALL have port rate_load, input, 1, single-cycle strobe that captures rate_in.
REQ-007 SHALL have port rate_ack, output, 1, single-cycle strobe when a captured rate becomes active.
REQ-008 SHALL have port clamped, output, 1, high while the active rate was limited by REQ-014.
REQ-009 SHALL have port q, output, 1, registered pulse train; each pulse is exactly 1 cycle high.
REQ-010 SHALL have port valid, output, 1, single-cycle strobe at each window end.
REQ-011 SHALL have port last_count, output, 32, pulses emitted in the window that just ended; updated with valid.

Function
REQ-012 SHALL keep window counter cnt: starts at CLK_FREQ-1, decrements each enabled cycle, reloads CLK_FREQ-1 after 0; the boundary cycle is cnt==0.
REQ-013 SHALL keep 33-bit accumulator acc (0 at window start): each enabled cycle sum=acc+rate_act; if sum>=CLK_FREQ, fire and acc<=sum-CLK_FREQ, else acc<=sum; acc<=0 on the boundary cycle.
REQ-014 SHALL set active rate rate_act=min(captured rate, CLK_FREQ/2) (integer divide) and set clamped=1 iff captured rate>CLK_FREQ/2, so q always has a low cycle between pulses.
REQ-015 SHALL register fire into q with 1-cycle latency; with en=1, exactly rate_act pulses per window.
REQ-016 SHALL count fires in a 32-bit per-window counter; on the boundary cycle, last_count<=count including that cycle's fire, valid<=1, counter<=0.
REQ-017 SHALL hold a pending register (value + flag) set by rate_load; a later rate_load before activation overwrites the value (last wins).
REQ-018 SHALL, with en=1, activate pending only at a boundary: rate_act and clamped update for the next window, pending clears, rate_ack pulses once in the following cycle.
REQ-019 SHALL, for rate_load on the boundary cycle itself, activate that rate_in at that boundary (bypass).
REQ-020 SHALL, with en=0, activate rate_load on the next cycle with rate_ack on that cycle; cnt=CLK_FREQ-1, acc=0, q=0, per-window counter=0, valid=0; last_count holds.
REQ-021 SHALL, on en 0->1, begin a fresh window on that cycle (cnt=CLK_FREQ-1, acc=0).
REQ-022 SHALL treat rate_in=0 as no pulses; last_count=0 each window.

Reset
REQ-023 SHALL on rst_n=0 immediately force q=0, rate_ack=0, valid=0, clamped=0, last_count=0, rate_act=0, pending cleared, acc=0, cnt=CLK_FREQ-1, per-window counter=0, at any point in a window.
REQ-024 SHALL after rst_n release emit no pulses until a rate is loaded.

Verification (CLK_FREQ=100)
REQ-025 SHALL cover: en=1, load 10 -> 10 q pulses, gaps 10 cycles, per window; valid each 100 cycles with last_count=10.
REQ-026 SHALL cover: load 0 -> q never high; last_count=0 every window.
REQ-027 SHALL cover: load 70 -> clamped=1, q high every other cycle, last_count=50.
REQ-028 SHALL cover: running at 10, load 25 then 30 mid-window -> current window ends with last_count=10, one rate_ack after the boundary, next window last_count=30.
REQ-029 SHALL cover: rst_n low at cycle 40 of a window -> q, valid, last_count 0 asynchronously; after release no pulses until reload.
REQ-030 SHALL cover: en=0, load 20 -> rate_ack next cycle; en=1 -> first valid 100 cycles later with last_count=20.
